// File: rtl/key_history_pkg.sv
// keypad_pkg: shared types and constants for the keypad history slice.
//   key_t       - 4-bit hex key code
//   kh_state_t  - key_history FSM states (IDLE, HELD)
//   ROW1..ROW4  - one-hot active-high scanner row encodings (row 1 = top)
//   COL0..COL3  - one-cold active-low scanner column encodings (col 0 = left)
//   KEY_MAP     - key code indexed by {row index, column index}, both 0-based
package keypad_pkg;

    typedef logic [3:0] key_t;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } kh_state_t;

    localparam logic [3:0] ROW1 = 4'b1000;
    localparam logic [3:0] ROW2 = 4'b0100;
    localparam logic [3:0] ROW3 = 4'b0010;
    localparam logic [3:0] ROW4 = 4'b0001;

    localparam logic [3:0] COL0 = 4'b0111;
    localparam logic [3:0] COL1 = 4'b1011;
    localparam logic [3:0] COL2 = 4'b1101;
    localparam logic [3:0] COL3 = 4'b1110;

    localparam key_t KEY_MAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

endpackage

// File: rtl/key_history_if.sv
// key_history_if: scanner-side inputs and digit outputs of key_history.
//   rows, debounced_col, enable  - scanner sample (driven by master)
//   digit_cur, digit_prev        - two most recent accepted digits
//   new_key                      - one-cycle pulse when the digits update
//   held                         - high while a press is being held off
// Modports: master = scanner/display side, slave = key_history.
interface key_history_if;
    import keypad_pkg::*;

    logic [3:0] rows;
    logic [3:0] debounced_col;
    logic       enable;
    key_t       digit_cur;
    key_t       digit_prev;
    logic       new_key;
    logic       held;

    modport master (
        output rows, debounced_col, enable,
        input  digit_cur, digit_prev, new_key, held
    );

    modport slave (
        input  rows, debounced_col, enable,
        output digit_cur, digit_prev, new_key, held
    );

endinterface

// File: rtl/key_history_decode.sv
// keypad_decode: combinational row/column to hex key decoder.
//   rows          in  4  one-hot active-high row drive
//   debounced_col in  4  one-cold active-low column
//   key           out 4  decoded hex key
//   valid         out 1  pattern maps to a key
// Build option KEY_HISTORY_MULTIKEY_REJECT_EN: when defined, only a single
// row bit and a single column bit are accepted; otherwise the top-most row
// and left-most column win.
module keypad_decode
    import keypad_pkg::*;
(
    input  logic [3:0] rows,
    input  logic [3:0] debounced_col,
    output key_t       key,
    output logic       valid
);

    logic [1:0] row_idx;
    logic [1:0] col_idx;
    logic       row_hit;
    logic       col_hit;

    // Bit 3 is row 1 / col 0, so scanning from the MSB gives the priority.
    always_comb begin
        row_idx = '0;
        col_idx = '0;
        row_hit = 1'b0;
        col_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!row_hit && rows[3-i]) begin
                row_idx = 2'(i);
                row_hit = 1'b1;
            end
            if (!col_hit && !debounced_col[3-i]) begin
                col_idx = 2'(i);
                col_hit = 1'b1;
            end
        end
    end

    assign key = KEY_MAP[{row_idx, col_idx}];

`ifdef KEY_HISTORY_MULTIKEY_REJECT_EN
    assign valid = $onehot(rows) && $onehot(~debounced_col);
`else
    assign valid = row_hit && col_hit;
`endif

endmodule

// File: rtl/key_history.sv
// key_history: turns scanner activity into one digit event per press and
// keeps the two most recent digits.
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   kh     key_history_if.slave (rows, debounced_col, enable in;
//          digit_cur, digit_prev, new_key, held out)
// Parameter HOLD_CYCLES (>=1): consecutive low cycles of enable required
// before the next press is accepted.
// Build option KEY_HISTORY_MULTIKEY_REJECT_EN selects strict decoding in
// keypad_decode.
module key_history
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    key_history_if.slave  kh
);

    localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  HOLD_LIM = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    kh_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    key_t             cur_q, cur_d;
    key_t             prev_q, prev_d;
    logic             pulse_q, pulse_d;

    key_t             dec_key;
    logic             dec_valid;

    keypad_decode u_decode (
        .rows          (kh.rows),
        .debounced_col (kh.debounced_col),
        .key           (dec_key),
        .valid         (dec_valid)
    );

    // Saturating increment: the counter must never wrap back into the window.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        prev_d  = prev_q;
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (kh.enable) begin
                    // Invalid codes still enter HELD so that the same press
                    // cannot be accepted later once it decodes cleanly.
                    state_d = HELD;
                    cnt_d   = '0;
                    if (dec_valid) begin
                        prev_d  = cur_q;
                        cur_d   = dec_key;
                        pulse_d = 1'b1;
                    end
                end
            end
            HELD: begin
                if (kh.enable) begin
                    cnt_d = '0;
                end else if (cnt_inc == HOLD_LIM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            prev_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign kh.digit_cur  = cur_q;
    assign kh.digit_prev = prev_q;
    assign kh.new_key    = pulse_q;
    assign kh.held       = (state_q == HELD);

endmodule
